// File: rtl/ram_responder_pkg.sv
// Shared pin/bit positions for the mobo RAM handshake and the responder state encoding.
package ram_responder_pkg;

  localparam int unsigned RAM_READ_PIN  = 0;
  localparam int unsigned RAM_WRITE_PIN = 1;

  localparam int unsigned RAM_ACK  = 0;
  localparam int unsigned RAM_ERR  = 1;
  localparam int unsigned RAM_BUSY = 2;

  typedef enum logic [1:0] {
    RAMR_IDLE = 2'd0,
    RAMR_BUSY = 2'd1,
    RAMR_ACK  = 2'd2
  } ramr_state_e;

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous word memory; read and write both registered on clk.
module ram_array #(
  parameter int unsigned word_width = 32,
  parameter int unsigned depth_log2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [depth_log2-1:0] addr,
  input  logic [word_width-1:0] wdata,
  output logic [word_width-1:0] rdata
);

  localparam int unsigned depth = 1 << depth_log2;

  logic [word_width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ram_responder.sv
// Device-side RAM answering the mobo ctrl/stat four-phase handshake with a
// fixed access latency and an error flag for out-of-range or malformed requests.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int unsigned word_width  = 32,
  parameter int unsigned depth_log2  = 10,
  parameter int unsigned wait_cycles = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_width-1:0] ctrl,
  output logic [word_width-1:0] stat,
  input  logic [word_width-1:0] addr,
  input  logic [word_width-1:0] data_in,
  output logic [word_width-1:0] data_out
);

  localparam int unsigned cnt_w = (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);

  ramr_state_e           state, state_nxt;
  logic [cnt_w-1:0]      cnt, cnt_nxt;
  logic [word_width-1:0] lat_addr, lat_addr_nxt;
  logic [word_width-1:0] lat_data, lat_data_nxt;
  logic                  lat_rd, lat_rd_nxt;
  logic                  lat_wr, lat_wr_nxt;
  logic                  ack_q, ack_nxt;
  logic                  err_q, err_nxt;
  logic                  busy_q, busy_nxt;
  logic [word_width-1:0] dout_q, dout_nxt;

  logic                  rd_pin, wr_pin, oor_c, we_c;
  logic [depth_log2-1:0] ram_addr_c;
  logic [word_width-1:0] rdata;
  logic                  unused_ctrl_bits;

  assign rd_pin           = ctrl[RAM_READ_PIN];
  assign wr_pin           = ctrl[RAM_WRITE_PIN];
  assign unused_ctrl_bits = ^ctrl[word_width-1:2];
  assign oor_c            = |lat_addr[word_width-1:depth_log2];

  // Present the live address while idle so the registered read is ready even with zero wait.
  assign ram_addr_c = (state == RAMR_IDLE) ? addr[depth_log2-1:0] : lat_addr[depth_log2-1:0];

  ram_array #(
    .word_width(word_width),
    .depth_log2(depth_log2)
  ) u_ram_array (
    .clk  (clk),
    .we   (we_c),
    .addr (ram_addr_c),
    .wdata(lat_data),
    .rdata(rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RAMR_IDLE;
      cnt      <= '0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_rd   <= 1'b0;
      lat_wr   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      dout_q   <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      lat_addr <= lat_addr_nxt;
      lat_data <= lat_data_nxt;
      lat_rd   <= lat_rd_nxt;
      lat_wr   <= lat_wr_nxt;
      ack_q    <= ack_nxt;
      err_q    <= err_nxt;
      busy_q   <= busy_nxt;
      dout_q   <= dout_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    lat_addr_nxt = lat_addr;
    lat_data_nxt = lat_data;
    lat_rd_nxt   = lat_rd;
    lat_wr_nxt   = lat_wr;
    ack_nxt      = ack_q;
    err_nxt      = err_q;
    busy_nxt     = busy_q;
    dout_nxt     = dout_q;
    we_c         = 1'b0;
    case (state)
      RAMR_IDLE: begin
        if (rd_pin || wr_pin) begin
          state_nxt    = RAMR_BUSY;
          cnt_nxt      = cnt_w'(wait_cycles);
          lat_addr_nxt = addr;
          lat_data_nxt = data_in;
          lat_rd_nxt   = rd_pin;
          lat_wr_nxt   = wr_pin;
          busy_nxt     = 1'b1;
        end
      end
      RAMR_BUSY: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - cnt_w'(1);
        end else begin
          state_nxt = RAMR_ACK;
          ack_nxt   = 1'b1;
          busy_nxt  = 1'b0;
          if (lat_rd && lat_wr) begin
            err_nxt = 1'b1;
          end else if (oor_c) begin
            err_nxt = 1'b1;
            if (lat_rd) dout_nxt = '0;
          end else if (lat_rd) begin
            dout_nxt = rdata;
          end else begin
            we_c = 1'b1;
          end
        end
      end
      RAMR_ACK: begin
        if (!rd_pin && !wr_pin) begin
          state_nxt = RAMR_IDLE;
          ack_nxt   = 1'b0;
          err_nxt   = 1'b0;
        end
      end
      default: state_nxt = RAMR_IDLE;
    endcase
  end

  always_comb begin
    stat           = '0;
    stat[RAM_ACK]  = ack_q;
    stat[RAM_ERR]  = err_q;
    stat[RAM_BUSY] = busy_q;
  end

  assign data_out = dout_q;

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: directed requests push expected ERR/data_out,
// a monitor pops on each rising ACK; latency and handshake timing checked inline.
module tb_ram_responder;

  localparam int unsigned WW = 32;

  logic          clk, rst;
  logic [WW-1:0] ctrl, stat, addr, data_in, data_out;
  logic [WW-1:0] ctrl1, stat1, addr1, data_in1, data_out1;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic          err;
    logic [WW-1:0] dout;
  } exp_t;

  exp_t          exp_q[$];
  logic [WW-1:0] mem_model[int];
  logic [WW-1:0] dout_model;

  ram_responder #(.word_width(32), .depth_log2(10), .wait_cycles(2)) dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .stat(stat),
    .addr(addr), .data_in(data_in), .data_out(data_out)
  );

  ram_responder #(.word_width(32), .depth_log2(10), .wait_cycles(0)) dut0 (
    .clk(clk), .rst(rst), .ctrl(ctrl1), .stat(stat1),
    .addr(addr1), .data_in(data_in1), .data_out(data_out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each new ACK against the oldest outstanding expectation.
  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    if (stat[0] && !prev_ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_ack actual=%h expected=none", stat);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_err", {31'd0, stat[1]}, {31'd0, e.err});
        check("sb_data_out", data_out, e.dout);
      end
    end
    prev_ack = stat[0];
  end

  // Issue one request on the wait_cycles=2 instance and walk the handshake.
  task automatic req(input logic [WW-1:0] c, input logic [WW-1:0] a, input logic [WW-1:0] d,
                     input int hold, input bit early_drop);
    exp_t e;
    int   lat;
    bit   rd, wr, oor;
    rd  = c[0];
    wr  = c[1];
    oor = (a >= 32'h400);
    e.err = 1'b0;
    if (rd && wr) e.err = 1'b1;
    else if (oor) begin
      e.err = 1'b1;
      if (rd) dout_model = '0;
    end else if (rd) dout_model = mem_model[int'(a)];
    else mem_model[int'(a)] = d;
    e.dout = dout_model;
    exp_q.push_back(e);

    @(posedge clk); #1;
    ctrl = c; addr = a; data_in = d;
    @(posedge clk);
    lat = 0;
    do begin
      @(posedge clk); lat++; #1;
      if (early_drop && lat == 1) ctrl = '0;
      if (!stat[0]) check("busy_while_waiting", stat, 32'h4);
    end while (!stat[0] && lat < 20);
    check("ack_latency", 32'(lat), 32'd3);
    if (!early_drop) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("hold_stat", stat, {30'd0, e.err, 1'b1});
        check("hold_data_out", data_out, e.dout);
      end
      ctrl = '0;
    end
    @(posedge clk); #1;
    check("ack_release", stat, 32'h0);
    check("release_data_out", data_out, e.dout);
  endtask

  // Zero-wait instance: ACK must appear after exactly one edge.
  task automatic req0(input logic [WW-1:0] c, input logic [WW-1:0] a, input logic [WW-1:0] d,
                      input logic [WW-1:0] exp_dout);
    @(posedge clk); #1;
    ctrl1 = c; addr1 = a; data_in1 = d;
    @(posedge clk);
    @(posedge clk); #1;
    check("w0_ack_after_1", stat1, 32'h1);
    check("w0_data_out", data_out1, exp_dout);
    ctrl1 = '0;
    @(posedge clk); #1;
    check("w0_release", stat1, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    ctrl = '0; addr = '0; data_in = '0;
    ctrl1 = '0; addr1 = '0; data_in1 = '0;
    dout_model = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_stat", stat, 32'h0);
      check("idle_data_out", data_out, 32'h0);
    end

    req(32'h2, 32'd5, 32'hDEADBEEF, 0, 1'b0);
    req(32'h1, 32'd5, 32'h0, 0, 1'b0);
    req(32'h2, 32'd0, 32'hA5A50000, 0, 1'b0);
    req(32'h1, 32'h400, 32'h0, 0, 1'b0);
    req(32'h1, 32'd0, 32'h0, 0, 1'b0);
    req(32'h2, 32'd7, 32'h77777777, 0, 1'b0);
    req(32'h3, 32'd7, 32'h00000BAD, 0, 1'b0);
    req(32'h1, 32'd7, 32'h0, 0, 1'b0);
    req(32'h1, 32'd5, 32'h0, 5, 1'b0);
    req(32'h1, 32'd0, 32'h0, 0, 1'b1);
    req(32'h2, 32'd9, 32'hCAFE0009, 0, 1'b0);

    // Abort a write with reset while BUSY; the write must not land.
    @(posedge clk); #1;
    ctrl = 32'h2; addr = 32'd9; data_in = 32'h1234;
    @(posedge clk);
    @(posedge clk); #1;
    check("mid_write_busy", stat, 32'h4);
    #2 rst = 1'b1;
    #1;
    check("async_reset_stat", stat, 32'h0);
    check("async_reset_data_out", data_out, 32'h0);
    ctrl = '0;
    @(posedge clk); #1 rst = 1'b0;
    dout_model = '0;
    req(32'h1, 32'd9, 32'h0, 0, 1'b0);

    req0(32'h2, 32'd3, 32'h33, 32'h0);
    req0(32'h1, 32'd3, 32'h0, 32'h33);

    repeat (2) @(posedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
